// File: rtl/dcache_sram_nway.sv
// N-way set-associative line store with true-LRU replacement and a built-in flush/write-back walker.
// Optional build macro DCACHE_FLUSH_INV_EN: the flush also invalidates every line it visits.
module dcache_sram_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = $clog2(SETS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [SET_W-1:0]  set_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              dirty_i,
  output logic              hit_o,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] data_o,
  input  logic              flush_i,
  output logic              flush_busy_o,
  output logic              flush_done_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [SET_W-1:0]  wb_set_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [LINE_W-1:0] wb_data_o
);
  localparam int PTR_W = SET_W + WAY_W;

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, WB = 2'd2, DONE = 2'd3} state_t;

  logic              valid_r [SETS][WAYS];
  logic              dirty_r [SETS][WAYS];
  logic [TAG_W-1:0]  tag_r   [SETS][WAYS];
  logic [LINE_W-1:0] data_r  [SETS][WAYS];
  logic [WAY_W-1:0]  age_r   [SETS][WAYS];

  state_t            state_r;
  logic [PTR_W-1:0]  ptr_r;
  logic              busy_r;
  logic              done_r;
  logic              wb_valid_r;

  logic              active_s, hit_any_s, inv_any_s, match_s, acc_s;
  logic [WAY_W-1:0]  hit_way_s, inv_way_s, old_way_s, victim_s, sel_way_s, sel_age_s;
  logic [SET_W-1:0]  ptr_set_s;
  logic [WAY_W-1:0]  ptr_way_s;
  logic              line_dirty_s, last_s, wb_acc_s, flush_clr_s, flush_inv_s;

  // Tag compare and victim choice for the addressed set; descending scan so the lowest index wins
  always_comb begin
    hit_any_s = 1'b0;
    inv_any_s = 1'b0;
    match_s   = 1'b0;
    hit_way_s = '0;
    inv_way_s = '0;
    old_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match_s   = valid_r[set_i][WAY_W'(w)] && (tag_r[set_i][WAY_W'(w)] == tag_i);
      hit_any_s = hit_any_s | match_s;
      hit_way_s = match_s ? WAY_W'(w) : hit_way_s;
      inv_any_s = inv_any_s | ~valid_r[set_i][WAY_W'(w)];
      inv_way_s = valid_r[set_i][WAY_W'(w)] ? inv_way_s : WAY_W'(w);
      old_way_s = (age_r[set_i][WAY_W'(w)] == WAY_W'(WAYS - 1)) ? WAY_W'(w) : old_way_s;
    end
  end

  assign active_s  = enable_i & ~busy_r;
  assign victim_s  = inv_any_s ? inv_way_s : old_way_s;
  assign sel_way_s = hit_any_s ? hit_way_s : victim_s;
  assign sel_age_s = age_r[set_i][sel_way_s];
  assign acc_s     = active_s & (write_i | hit_any_s);

  assign hit_o   = active_s & hit_any_s;
  assign valid_o = active_s & valid_r[set_i][sel_way_s];
  assign dirty_o = active_s & dirty_r[set_i][sel_way_s];
  assign tag_o   = active_s ? tag_r[set_i][sel_way_s] : '0;
  assign data_o  = active_s ? data_r[set_i][sel_way_s] : '0;

  assign ptr_set_s    = ptr_r[PTR_W-1:WAY_W];
  assign ptr_way_s    = ptr_r[WAY_W-1:0];
  assign line_dirty_s = valid_r[ptr_set_s][ptr_way_s] & dirty_r[ptr_set_s][ptr_way_s];
  assign last_s       = (ptr_r == {PTR_W{1'b1}});
  assign wb_acc_s     = wb_valid_r & wb_ready_i;
`ifdef DCACHE_FLUSH_INV_EN
  assign flush_inv_s  = ((state_r == SCAN) & ~line_dirty_s) | wb_acc_s;
`else
  assign flush_inv_s  = 1'b0;
`endif
  assign flush_clr_s  = wb_acc_s | flush_inv_s;

  assign flush_busy_o = busy_r;
  assign flush_done_o = done_r;
  assign wb_valid_o   = wb_valid_r;
  assign wb_set_o     = wb_valid_r ? ptr_set_s : '0;
  assign wb_tag_o     = wb_valid_r ? tag_r[ptr_set_s][ptr_way_s] : '0;
  assign wb_data_o    = wb_valid_r ? data_r[ptr_set_s][ptr_way_s] : '0;

  // Line arrays and LRU ages: controller writes/hits when idle, flush clears while busy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_r[SET_W'(s)][WAY_W'(w)] <= 1'b0;
          dirty_r[SET_W'(s)][WAY_W'(w)] <= 1'b0;
          tag_r[SET_W'(s)][WAY_W'(w)]   <= '0;
          data_r[SET_W'(s)][WAY_W'(w)]  <= '0;
          age_r[SET_W'(s)][WAY_W'(w)]   <= WAY_W'(w);
        end
      end
    end else begin
      if (active_s && write_i) begin
        valid_r[set_i][sel_way_s] <= 1'b1;
        tag_r[set_i][sel_way_s]   <= tag_i;
        data_r[set_i][sel_way_s]  <= data_i;
        dirty_r[set_i][sel_way_s] <= hit_any_s ? (dirty_r[set_i][sel_way_s] | dirty_i) : dirty_i;
      end
      if (acc_s) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == sel_way_s) begin
            age_r[set_i][WAY_W'(w)] <= '0;
          end else if (age_r[set_i][WAY_W'(w)] < sel_age_s) begin
            age_r[set_i][WAY_W'(w)] <= age_r[set_i][WAY_W'(w)] + 1'b1;
          end
        end
      end
      if (flush_clr_s) begin
        dirty_r[ptr_set_s][ptr_way_s] <= 1'b0;
      end
      if (flush_inv_s) begin
        valid_r[ptr_set_s][ptr_way_s] <= 1'b0;
      end
    end
  end

  // Flush walker: visits lines in {set,way} order and holds each write-back beat until accepted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      ptr_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      wb_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (flush_i) begin
            state_r <= SCAN;
            ptr_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        SCAN: begin
          if (line_dirty_s) begin
            state_r    <= WB;
            wb_valid_r <= 1'b1;
          end else if (last_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            ptr_r <= ptr_r + 1'b1;
          end
        end
        WB: begin
          if (wb_ready_i) begin
            wb_valid_r <= 1'b0;
            if (last_s) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= SCAN;
              ptr_r   <= ptr_r + 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          wb_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Randomised bench for dcache_sram_nway against a recency-list cache model with a flush/write-back monitor.
module tb_dcache_sram_nway;
  localparam int WAYS   = 4;
  localparam int SETS   = 16;
  localparam int TAG_W  = 23;
  localparam int LINE_W = 256;
  localparam int SET_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              enable_i = 1'b0, write_i = 1'b0, dirty_i = 1'b0, flush_i = 1'b0, wb_ready_i = 1'b0;
  logic [SET_W-1:0]  set_i = '0;
  logic [TAG_W-1:0]  tag_i = '0;
  logic [LINE_W-1:0] data_i = '0;
  logic              hit_o, valid_o, dirty_o, flush_busy_o, flush_done_o, wb_valid_o;
  logic [TAG_W-1:0]  tag_o, wb_tag_o;
  logic [LINE_W-1:0] data_o, wb_data_o;
  logic [SET_W-1:0]  wb_set_o;

  always #5 clk_i = ~clk_i;

  dcache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i), .set_i(set_i),
    .tag_i(tag_i), .data_i(data_i), .dirty_i(dirty_i), .hit_o(hit_o), .valid_o(valid_o),
    .dirty_o(dirty_o), .tag_o(tag_o), .data_o(data_o), .flush_i(flush_i),
    .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o), .wb_valid_o(wb_valid_o),
    .wb_ready_i(wb_ready_i), .wb_set_o(wb_set_o), .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: m_ord[s][0] is the most recently used way, m_ord[s][WAYS-1] the least
  bit                m_valid [SETS][WAYS];
  bit                m_dirty [SETS][WAYS];
  logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
  logic [LINE_W-1:0] m_data  [SETS][WAYS];
  int                m_ord   [SETS][WAYS];

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = '0;
        m_data[s][w]  = '0;
        m_ord[s][w]   = w;
      end
    end
  endtask

  task automatic m_find(input int s, input logic [TAG_W-1:0] t, output bit hit, output int way);
    hit = 1'b0;
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (!hit && m_valid[s][w] && m_tag[s][w] == t) begin hit = 1'b1; way = w; end
    if (!hit) begin
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[s][w]) way = w;
      if (way < 0) way = m_ord[s][WAYS-1];
    end
  endtask

  task automatic m_touch(input int s, input int w);
    int p;
    p = 0;
    for (int i = 0; i < WAYS; i++)
      if (m_ord[s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_ord[s][i] = m_ord[s][i-1];
    m_ord[s][0] = w;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic access(input bit wr, input int s, input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] d,
                        input bit dy, output bit o_hit, output logic [TAG_W-1:0] o_tag);
    bit h;
    int w;
    @(posedge clk_i); #1;
    enable_i = 1'b1; write_i = wr; set_i = SET_W'(s); tag_i = t; data_i = d; dirty_i = dy;
    #3;
    m_find(s, t, h, w);
    check("hit", LINE_W'(hit_o), LINE_W'(h));
    check("valid", LINE_W'(valid_o), LINE_W'(m_valid[s][w]));
    check("dirty", LINE_W'(dirty_o), LINE_W'(m_dirty[s][w]));
    check("tag", LINE_W'(tag_o), LINE_W'(m_tag[s][w]));
    check("data", data_o, m_data[s][w]);
    o_hit = hit_o;
    o_tag = tag_o;
    if (wr) begin
      if (h) begin
        m_data[s][w]  = d;
        m_dirty[s][w] = m_dirty[s][w] | dy;
      end else begin
        m_valid[s][w] = 1'b1; m_tag[s][w] = t; m_data[s][w] = d; m_dirty[s][w] = dy;
      end
      m_touch(s, w);
    end else if (h) begin
      m_touch(s, w);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1; enable_i = 1'b0; write_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    m_reset();
  endtask

  // Flush with a fixed number of refused cycles per beat; optional ignored traffic while busy
  task automatic do_flush(input int stall, input bit rnd_traffic);
    logic [SET_W-1:0]  e_set[$];
    logic [TAG_W-1:0]  e_tag[$];
    logic [LINE_W-1:0] e_data[$];
    int busy_cnt = 0, done_cnt = 0, beats = 0, stalls = 0, hold = 0, cyc = 0, ndirty;
    bit prev_busy = 1'b1, prev_done = 1'b0, leave = 1'b0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin
          e_set.push_back(SET_W'(s)); e_tag.push_back(m_tag[s][w]); e_data.push_back(m_data[s][w]);
        end
    ndirty = e_set.size();
    @(posedge clk_i); #1;
    flush_i = 1'b1; enable_i = 1'b0; write_i = 1'b0; wb_ready_i = (stall == 0);
    while (!leave && cyc < 2000) begin
      @(posedge clk_i); #1;
      cyc++;
      if (prev_busy && !prev_done && rnd_traffic) begin
        flush_i = 1'($urandom_range(0, 1)); enable_i = 1'($urandom_range(0, 1));
        write_i = 1'($urandom_range(0, 1)); set_i = SET_W'($urandom_range(0, SETS - 1));
        tag_i = TAG_W'($urandom_range(0, 7)); data_i = rand_line(); dirty_i = 1'b1;
      end else begin
        flush_i = 1'b0; enable_i = 1'b0; write_i = 1'b0;
      end
      wb_ready_i = (hold >= stall);
      #3;
      if (flush_busy_o) begin
        busy_cnt++;
        check("busy_lookup_quiet", LINE_W'({hit_o, valid_o, dirty_o, tag_o}) | data_o, '0);
      end
      if (flush_done_o) done_cnt++;
      if (wb_valid_o) begin
        check("wb_extra", LINE_W'(beats < ndirty), LINE_W'(1'b1));
        if (beats < ndirty) begin
          check("wb_set", LINE_W'(wb_set_o), LINE_W'(e_set[beats]));
          check("wb_tag", LINE_W'(wb_tag_o), LINE_W'(e_tag[beats]));
          check("wb_data", wb_data_o, e_data[beats]);
        end
        if (wb_ready_i) begin beats++; hold = 0; end
        else begin hold++; stalls++; end
      end
      if (!flush_busy_o) leave = 1'b1;
      prev_busy = flush_busy_o;
      prev_done = flush_done_o;
    end
    flush_i = 1'b0; enable_i = 1'b0; write_i = 1'b0; wb_ready_i = 1'b0;
    check("flush_terminated", LINE_W'(leave), LINE_W'(1'b1));
    check("busy_cycles", LINE_W'(busy_cnt), LINE_W'(SETS * WAYS + 1 + ndirty + stalls));
    check("done_pulses", LINE_W'(done_cnt), LINE_W'(1));
    check("wb_beats", LINE_W'(beats), LINE_W'(ndirty));
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_dirty[s][w] = 1'b0;
`ifdef DCACHE_FLUSH_INV_EN
        m_valid[s][w] = 1'b0;
`endif
      end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit oh;
    logic [TAG_W-1:0] ot;
    logic [LINE_W-1:0] l55;
    int cyc;
    l55 = {(LINE_W / 8){8'h55}};
    m_reset();
    enable_i = 1'b1; set_i = 4'd3; tag_i = 23'h1;
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_lookup", LINE_W'({hit_o, valid_o, dirty_o, tag_o}) | data_o, '0);
    check("rst_flush", LINE_W'({flush_busy_o, flush_done_o, wb_valid_o, wb_set_o, wb_tag_o}) | wb_data_o, '0);
    #1 rst_i = 1'b0; enable_i = 1'b0;

    access(1'b0, 3, 23'h1, '0, 1'b0, oh, ot);
    check("post_rst_busy", LINE_W'(flush_busy_o), LINE_W'(1'b0));

    // Fill set 5 and evict the oldest fill
    access(1'b1, 5, 23'hA, rand_line(), 1'b0, oh, ot);
    access(1'b1, 5, 23'hB, rand_line(), 1'b0, oh, ot);
    access(1'b1, 5, 23'hC, rand_line(), 1'b0, oh, ot);
    access(1'b1, 5, 23'hD, rand_line(), 1'b0, oh, ot);
    access(1'b0, 5, 23'hE, '0, 1'b0, oh, ot);
    check("miss_victim_tag", LINE_W'(ot), LINE_W'(23'hA));
    check("miss_valid", LINE_W'(valid_o), LINE_W'(1'b1));
    access(1'b1, 5, 23'hE, rand_line(), 1'b0, oh, ot);
    access(1'b0, 5, 23'hA, '0, 1'b0, oh, ot);
    check("evicted_a", LINE_W'(oh), LINE_W'(1'b0));
    access(1'b0, 5, 23'hB, '0, 1'b0, oh, ot);
    check("kept_b", LINE_W'(oh), LINE_W'(1'b1));

    // Read hit refreshes A, so B becomes the victim
    do_reset();
    access(1'b1, 5, 23'hA, rand_line(), 1'b0, oh, ot);
    access(1'b1, 5, 23'hB, rand_line(), 1'b0, oh, ot);
    access(1'b1, 5, 23'hC, rand_line(), 1'b0, oh, ot);
    access(1'b1, 5, 23'hD, rand_line(), 1'b0, oh, ot);
    access(1'b0, 5, 23'hA, '0, 1'b0, oh, ot);
    access(1'b1, 5, 23'hE, rand_line(), 1'b0, oh, ot);
    check("lru_victim_b", LINE_W'(ot), LINE_W'(23'hB));
    access(1'b0, 5, 23'hA, '0, 1'b0, oh, ot);
    check("a_still_hits", LINE_W'(oh), LINE_W'(1'b1));

    // Dirty write hit then flush with three refused cycles
    do_reset();
    access(1'b1, 2, 23'h7, rand_line(), 1'b0, oh, ot);
    access(1'b1, 2, 23'h7, l55, 1'b1, oh, ot);
    check("write_hit", LINE_W'(oh), LINE_W'(1'b1));
    do_flush(3, 1'b0);
    access(1'b0, 2, 23'h7, '0, 1'b0, oh, ot);
    check("clean_after_flush", LINE_W'(dirty_o), LINE_W'(1'b0));
    do_flush(0, 1'b0);
    access(1'b0, 2, 23'h7, '0, 1'b0, oh, ot);

    // Reset while a write-back beat is pending
    do_reset();
    access(1'b1, 1, 23'h3, rand_line(), 1'b1, oh, ot);
    access(1'b1, 9, 23'h4, rand_line(), 1'b1, oh, ot);
    @(posedge clk_i); #1;
    enable_i = 1'b0; write_i = 1'b0; flush_i = 1'b1; wb_ready_i = 1'b0;
    @(posedge clk_i); #1 flush_i = 1'b0;
    cyc = 0;
    while (!wb_valid_o && cyc < 200) begin @(posedge clk_i); #4; cyc++; end
    check("wb_reached", LINE_W'(wb_valid_o), LINE_W'(1'b1));
    #1 rst_i = 1'b1;
    #1;
    check("rst_drops_wb", LINE_W'(wb_valid_o), LINE_W'(1'b0));
    check("rst_drops_busy", LINE_W'(flush_busy_o), LINE_W'(1'b0));
    repeat (2) begin @(posedge clk_i); #2; check("no_done_in_rst", LINE_W'(flush_done_o), LINE_W'(1'b0)); end
    @(posedge clk_i); #1 rst_i = 1'b0;
    m_reset();
    repeat (2) begin @(posedge clk_i); #2; check("no_done_after_rst", LINE_W'(flush_done_o | flush_busy_o), LINE_W'(1'b0)); end
    do_flush(0, 1'b0);
    access(1'b0, 1, 23'h3, '0, 1'b0, oh, ot);

    // Random traffic with periodic flushes
    for (int i = 0; i < 400; i++) begin
      int s;
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SETS - 1)) : int'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), s, TAG_W'($urandom_range(0, 7)), rand_line(),
             1'($urandom_range(0, 1)), oh, ot);
      if (i % 100 == 99) do_flush(int'($urandom_range(0, 2)), 1'b1);
    end
    @(posedge clk_i); #1 enable_i = 1'b0; write_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_sram_nway.md
Name: dcache_sram_nway

Overview:
Parametrised N-way set-associative data-cache storage array with true-LRU replacement and per-line valid/dirty bits. It sits under the dcache controller. Lookup is combinational, so hit, line data and victim info are available in the same cycle. A built-in flush engine walks every line and streams dirty lines out over a valid/ready write-back port, so the controller needs no flush FSM of its own.

Parameters:
WAYS, 4, associativity; power of 2, range 2..8; WAY_W = log2(WAYS)
SETS, 16, number of sets; power of 2; SET_W = log2(SETS)
TAG_W, 23, stored address-tag width
LINE_W, 256, cache line width in bits

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
enable_i  in  1  access strobe from controller
write_i  in  1  1 = write/fill line, 0 = lookup only
set_i  in  SET_W  set index
tag_i  in  TAG_W  request tag
data_i  in  LINE_W  write/fill data
dirty_i  in  1  dirty value for a written line
hit_o  out  1  tag match on a valid way
valid_o  out  1  valid bit of the selected line
dirty_o  out  1  dirty bit of the selected line
tag_o  out  TAG_W  tag of the selected line
data_o  out  LINE_W  data of the selected line
flush_i  in  1  single-cycle flush request
flush_busy_o  out  1  flush engine active
flush_done_o  out  1  one-cycle pulse at flush completion
wb_valid_o  out  1  write-back beat valid
wb_ready_i  in  1  write-back accept
wb_set_o  out  SET_W  write-back set index
wb_tag_o  out  TAG_W  write-back tag
wb_data_o  out  LINE_W  write-back line data

Behaviour:
- Reset clears all valid, dirty, tag and data bits. LRU age of way w is set to w in every set. FSM goes to IDLE. All outputs are 0.
- Lookup (combinational):
  - hit = enable_i & !flush_busy_o & any way with valid & tag == tag_i.
  - Selected line = the hit way. On a miss it is the victim way: the lowest-index invalid way, else the way with age WAYS-1.
  - tag_o/data_o/valid_o/dirty_o show the selected line, so the controller can see the dirty victim before it issues the fill.
  - When enable_i=0 or flush_busy_o=1, all lookup outputs are 0.
- Write (posedge, enable_i & write_i & !flush_busy_o):
  - On hit: data <= data_i, dirty <= dirty | dirty_i.
  - On miss: fill the victim with valid=1, tag=tag_i, data=data_i, dirty=dirty_i.
  - The new contents are visible combinationally in the next cycle.
- LRU update (posedge, on read hit or any write): the accessed way's age becomes 0. Every way whose age was below the accessed way's old age increments by 1. Ages in a set always remain a permutation of 0..WAYS-1. A read miss leaves LRU unchanged.
- Flush FSM states: IDLE, SCAN, WB, DONE. Pointer = {set, way}, starting at 0/0.
  - IDLE: flush_i=1 moves to SCAN with pointer 0/0. flush_busy_o is 1 from the next cycle through the DONE cycle.
  - SCAN:
    - If the line is valid & dirty, go to WB.
    - Otherwise advance the pointer: way+1, wrapping to 0 with set+1. From the last line, go to DONE.
  - WB:
    - wb_valid_o=1 and wb_set/tag/data_o show the pointed line; they are held stable until accepted.
    - On wb_valid_o & wb_ready_i: clear dirty, then advance as in SCAN.
  - DONE: flush_done_o=1 for one cycle, then IDLE.
- Flush boundary conditions:
  - flush_i during busy is ignored.
  - Controller accesses during busy are ignored: no array or LRU change.
  - The flush does not modify LRU.
  - Timing with no dirty lines: busy lasts SETS*WAYS SCAN cycles + 1 DONE cycle. Each dirty line adds 1 cycle plus any wb_ready_i stall cycles.
- Reset mid-flush: wb_valid_o and flush_busy_o drop immediately (asynchronous). Arrays clear, FSM returns to IDLE, and no flush_done_o pulse is produced.

Optional Feature:
DCACHE_FLUSH_INV_EN.
- Defined: every line visited by the flush is invalidated (valid <= 0, dirty <= 0) when the pointer leaves it, so the cache is empty after flush_done_o.
- Undefined: only the dirty bit of written-back lines is cleared; valid, tag, data and LRU are kept.

Test Plan:
- Reset; lookup set 3 tag 0x1 -> hit_o=0, valid_o=0, tag_o=0, flush_busy_o=0.
- Set 5, fill tags 0xA,0xB,0xC,0xD; lookup tag 0xE -> hit_o=0, valid_o=1, tag_o=0xA; fill 0xE -> lookup 0xA misses, 0xB hits.
- Set 5, access order 0xA,0xB,0xC,0xD, read hit 0xA, fill 0xE -> victim is 0xB; lookup 0xA still hits.
- Write hit set 2 tag 0x7 with dirty_i=1, data 0x55..55; flush with wb_ready_i low for 3 cycles -> wb_valid_o=1 with set=2, tag=0x7, data=0x55..55, stable for 3 cycles, one beat accepted; flush_done_o pulses once; dirty_o=0 afterwards.
- Flush with no dirty lines (16x4) -> flush_busy_o high exactly 65 cycles, wb_valid_o never 1, exactly one flush_done_o pulse; with DCACHE_FLUSH_INV_EN, all later lookups miss.
- Assert rst_i while in WB -> wb_valid_o=0 immediately, no flush_done_o; a new flush then completes normally in 65 cycles.
